dma_chan_addr_unit: RTL and testbench

Parametrised multi-channel address/word-count engine for the DMA8237A family; successor to the single-path DMA datapath. It holds per-channel base and current address and word-count registers, programmed bytewise by the CPU in idle cycles. For each granted transfer it drives the memory address with an ADSTB-qualified upper-address phase, then steps address and count. It reports terminal count (TC) per channel, with optional autoinitialize reload.

---
 rtl/dma_chan_addr_unit_pkg.sv | 29 ++
 rtl/dma_chan_addr_unit_if.sv | 46 ++++
 rtl/dma_chan_addr_unit_regs.sv | 94 +++++++++
 rtl/dma_chan_addr_unit.sv | 172 +++++++++++++++++
 tb/tb_dma_chan_addr_unit.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_chan_addr_unit_pkg.sv
// dma_chan_addr_unit_pkg
// Shared definitions for the DMA channel address unit:
//   - FSM state encodings (ST_IDLE, ST_UPPER, ST_ADDR)
//   - register-select encoding for the CPU programming port (SEL_ADDR, SEL_CNT)
//   - byte-select helpers used to size the shared byte pointer
package dma_chan_addr_unit_pkg;

  localparam int BYTE_W = 8;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_UPPER = 2'd1;
  localparam logic [1:0] ST_ADDR  = 2'd2;

  // prog_sel encoding
  localparam logic SEL_ADDR = 1'b0;
  localparam logic SEL_CNT  = 1'b1;

  // Number of programming bytes in a register of the given width.
  function automatic int num_bytes(input int width);
    return width / BYTE_W;
  endfunction

  // Index width for n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dma_chan_addr_unit_if.sv
// dma_chan_addr_unit_if
// Groups the CPU programming port and the transfer/bus port of the DMA
// channel address unit.
//   master modport : CPU + bus controller side (drives strobes, sees bus)
//   slave modport  : address unit side
// Handshake semantics: there is no valid/ready pair here. prog_we, prog_re,
// clr_bp, svc_req and xfer_ack are single-cycle qualifiers sampled on the
// rising edge; the unit accepts prog_we/prog_re/svc_req only while idle and
// xfer_ack only in the address phase, and silently drops them otherwise.
// prog_rdata is valid the cycle after an accepted prog_re; addr_out is
// valid while aen is high.
interface dma_chan_addr_unit_if
  import dma_chan_addr_unit_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 16
);
  localparam int CH_W = idx_w(NUM_CH);

  logic              prog_we;
  logic              prog_re;
  logic              prog_sel;
  logic [CH_W-1:0]   prog_ch;
  logic [7:0]        prog_wdata;
  logic [7:0]        prog_rdata;
  logic              clr_bp;
  logic              svc_req;
  logic [CH_W-1:0]   svc_ch;
  logic              xfer_ack;
  logic              aen;
  logic              adstb;
  logic [ADDR_W-1:0] addr_out;

  modport master (
    output prog_we, prog_re, prog_sel, prog_ch, prog_wdata, clr_bp,
    output svc_req, svc_ch, xfer_ack,
    input  prog_rdata, aen, adstb, addr_out
  );

  modport slave (
    input  prog_we, prog_re, prog_sel, prog_ch, prog_wdata, clr_bp,
    input  svc_req, svc_ch, xfer_ack,
    output prog_rdata, aen, adstb, addr_out
  );

endinterface

// File: rtl/dma_chan_addr_unit_regs.sv
// dma_chan_regs
// One channel's address and word-count registers.
//   clk, rst_n           : clock, asynchronous active-low reset
//   wr_en/wr_sel/wr_byte : byte write of the address or count register
//   wr_data              : write byte
//   step                 : advance this channel by one transfer
//   dec                  : step the address downwards instead of upwards
//   autoinit             : reload from base on terminal count
//   cur_addr, cur_cnt    : current copies
//   tc                   : current count is zero (next step is terminal)
//   reload               : next step reloads from base
// Build option DMA_AUTOINIT_EN: when defined, base copies exist and the
// autoinit input is honoured; otherwise terminal count always wraps.
module dma_chan_regs
  import dma_chan_addr_unit_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16,
  parameter int BP_W   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [BP_W-1:0]   wr_byte,
  input  logic [7:0]        wr_data,
  input  logic              step,
  input  logic              dec,
  input  logic              autoinit,
  output logic [ADDR_W-1:0] cur_addr,
  output logic [CNT_W-1:0]  cur_cnt,
  output logic              tc,
  output logic              reload
);

  localparam int A_BYTES = num_bytes(ADDR_W);
  localparam int C_BYTES = num_bytes(CNT_W);

  logic [ADDR_W-1:0] next_addr;

  assign tc        = (cur_cnt == '0);
  assign next_addr = dec ? (cur_addr - ADDR_W'(1)) : (cur_addr + ADDR_W'(1));

`ifdef DMA_AUTOINIT_EN
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  base_cnt;

  assign reload = tc & autoinit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_addr <= '0;
      base_cnt  <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < A_BYTES; b++)
        if (wr_sel == SEL_ADDR && int'(wr_byte) == b) base_addr[b*8 +: 8] <= wr_data;
      for (int b = 0; b < C_BYTES; b++)
        if (wr_sel == SEL_CNT && int'(wr_byte) == b) base_cnt[b*8 +: 8] <= wr_data;
    end
  end
`else
  logic unused_autoinit;
  assign unused_autoinit = autoinit;
  assign reload          = 1'b0;
`endif

  // Decrementing a zero count naturally wraps it to all-ones, so the
  // non-reload terminal case needs no special handling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr <= '0;
      cur_cnt  <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < A_BYTES; b++)
        if (wr_sel == SEL_ADDR && int'(wr_byte) == b) cur_addr[b*8 +: 8] <= wr_data;
      for (int b = 0; b < C_BYTES; b++)
        if (wr_sel == SEL_CNT && int'(wr_byte) == b) cur_cnt[b*8 +: 8] <= wr_data;
    end else if (step) begin
`ifdef DMA_AUTOINIT_EN
      if (reload) begin
        cur_addr <= base_addr;
        cur_cnt  <= base_cnt;
      end else begin
        cur_addr <= next_addr;
        cur_cnt  <= cur_cnt - CNT_W'(1);
      end
`else
      cur_addr <= next_addr;
      cur_cnt  <= cur_cnt - CNT_W'(1);
`endif
    end
  end

endmodule

// File: rtl/dma_chan_addr_unit.sv
// dma_chan_addr_unit
// Multi-channel DMA address / word-count engine. Holds per-channel address
// and count registers (programmed bytewise while idle), runs one transfer
// per svc_req with an optional ADSTB upper-address phase, and reports
// terminal count per channel.
// Ports:
//   CLK, RESET_N : clock, asynchronous active-low reset
//   bus          : programming + transfer port (dma_chan_addr_unit_if.slave)
//   cfg_dec      : per-channel address decrement
//   cfg_autoinit : per-channel autoinitialize (build option DMA_AUTOINIT_EN)
//   status_rd    : read-to-clear of tc_status
//   busy         : FSM not idle
//   tc_pulse     : one-cycle terminal-count flag per channel
//   tc_status    : sticky terminal-count bits
//   state_dbg    : current FSM state
// Build option DMA_AUTOINIT_EN enables base registers and autoinit reload.
module dma_chan_addr_unit
  import dma_chan_addr_unit_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  dma_chan_addr_unit_if.slave  bus,
  input  logic [NUM_CH-1:0]    cfg_dec,
  input  logic [NUM_CH-1:0]    cfg_autoinit,
  input  logic                 status_rd,
  output logic                 busy,
  output logic [NUM_CH-1:0]    tc_pulse,
  output logic [NUM_CH-1:0]    tc_status,
  output logic [1:0]           state_dbg
);

  localparam int CH_W      = idx_w(NUM_CH);
  localparam int A_BYTES   = num_bytes(ADDR_W);
  localparam int C_BYTES   = num_bytes(CNT_W);
  localparam int MAX_BYTES = (A_BYTES > C_BYTES) ? A_BYTES : C_BYTES;
  localparam int BP_W      = idx_w(MAX_BYTES);

  logic [1:0]        state;
  logic [CH_W-1:0]   cur_ch;
  logic [CH_W-1:0]   last_ch;
  logic [ADDR_W-9:0] last_upper;
  logic              upper_valid;
  logic [BP_W-1:0]   bp;
  logic [BP_W-1:0]   bp_last;

  logic [ADDR_W-1:0] ch_addr [NUM_CH];
  logic [CNT_W-1:0]  ch_cnt  [NUM_CH];
  logic [NUM_CH-1:0] ch_tc, ch_reload, step_v, wr_v, tc_set;

  logic       acc_we, acc_re, upper_hit;
  logic [7:0] rd_byte;

  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;
  assign bus.aen   = busy;
  assign bus.adstb = (state == ST_UPPER);
  assign bus.addr_out = busy ? ch_addr[cur_ch] : '0;

  assign acc_we  = bus.prog_we & ~busy & (int'(bus.prog_ch) < NUM_CH);
  assign acc_re  = bus.prog_re & ~busy & (int'(bus.prog_ch) < NUM_CH);
  assign bp_last = (bus.prog_sel == SEL_CNT) ? BP_W'(C_BYTES - 1) : BP_W'(A_BYTES - 1);

  // Skip the ADSTB phase only when the latched upper byte is still on the
  // bus for this very channel.
  assign upper_hit = upper_valid && (bus.svc_ch == last_ch) &&
                     (ch_addr[bus.svc_ch][ADDR_W-1:8] == last_upper);

  always_comb begin
    step_v = '0;
    wr_v   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      step_v[c] = (state == ST_ADDR) && bus.xfer_ack && (int'(cur_ch) == c);
      wr_v[c]   = acc_we && (int'(bus.prog_ch) == c);
    end
  end

  assign tc_set = step_v & ch_tc;

  always_comb begin
    rd_byte = '0;
    if (bus.prog_sel == SEL_CNT) begin
      for (int b = 0; b < C_BYTES; b++)
        if (int'(bp) == b) rd_byte = ch_cnt[bus.prog_ch][b*8 +: 8];
    end else begin
      for (int b = 0; b < A_BYTES; b++)
        if (int'(bp) == b) rd_byte = ch_addr[bus.prog_ch][b*8 +: 8];
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    dma_chan_regs #(
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W),
      .BP_W   (BP_W)
    ) u_regs (
      .clk      (CLK),
      .rst_n    (RESET_N),
      .wr_en    (wr_v[c]),
      .wr_sel   (bus.prog_sel),
      .wr_byte  (bp),
      .wr_data  (bus.prog_wdata),
      .step     (step_v[c]),
      .dec      (cfg_dec[c]),
      .autoinit (cfg_autoinit[c]),
      .cur_addr (ch_addr[c]),
      .cur_cnt  (ch_cnt[c]),
      .tc       (ch_tc[c]),
      .reload   (ch_reload[c])
    );
  end

  // Byte pointer and read-data register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      bp             <= '0;
      bus.prog_rdata <= '0;
    end else begin
      if (bus.clr_bp)                  bp <= '0;
      else if (acc_we || acc_re)       bp <= (bp >= bp_last) ? '0 : bp + BP_W'(1);
      if (acc_re) bus.prog_rdata <= rd_byte;
    end
  end

  // Transfer FSM and upper-address tracking
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= ST_IDLE;
      cur_ch      <= '0;
      last_ch     <= '0;
      last_upper  <= '0;
      upper_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.svc_req && (int'(bus.svc_ch) < NUM_CH)) begin
            cur_ch <= bus.svc_ch;
            state  <= upper_hit ? ST_ADDR : ST_UPPER;
          end
        end
        ST_UPPER: begin
          last_upper <= ch_addr[cur_ch][ADDR_W-1:8];
          last_ch    <= cur_ch;
          state      <= ST_ADDR;
        end
        ST_ADDR: begin
          if (bus.xfer_ack) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      // A reprogram or a reload may change the upper byte behind our back.
      if (acc_we || |(step_v & ch_reload)) upper_valid <= 1'b0;
      else if (state == ST_UPPER)          upper_valid <= 1'b1;
    end
  end

  // Terminal-count reporting; a new TC beats a simultaneous status read.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tc_pulse  <= '0;
      tc_status <= '0;
    end else begin
      tc_pulse  <= tc_set;
      tc_status <= (status_rd ? '0 : tc_status) | tc_set;
    end
  end

endmodule

// File: tb/tb_dma_chan_addr_unit.sv
// tb_dma_chan_addr_unit
// Directed bench for dma_chan_addr_unit: programming/readback, increment and
// decrement transfers with ADSTB, terminal count, autoinit (both builds),
// access blocking while busy, clr_bp, and asynchronous reset mid-transfer.
module tb_dma_chan_addr_unit;
  import dma_chan_addr_unit_pkg::*;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 16;
  localparam int CNT_W  = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NUM_CH-1:0] cfg_dec, cfg_autoinit, tc_pulse, tc_status;
  logic              status_rd, busy;
  logic [1:0]        state_dbg;

  dma_chan_addr_unit_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) bus ();

  dma_chan_addr_unit #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .CLK          (clk),
    .RESET_N      (rst_n),
    .bus          (bus),
    .cfg_dec      (cfg_dec),
    .cfg_autoinit (cfg_autoinit),
    .status_rd    (status_rd),
    .busy         (busy),
    .tc_pulse     (tc_pulse),
    .tc_status    (tc_status),
    .state_dbg    (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];   // expected prog_rdata bytes
  logic [15:0] addr_q[$];  // expected addr_out per transfer

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic prog_wr(input int ch, input logic sel, input logic [7:0] d, input logic clr);
    bus.prog_we = 1'b1; bus.prog_sel = sel; bus.prog_ch = 2'(ch);
    bus.prog_wdata = d; bus.clr_bp = clr;
    @(negedge clk);
    bus.prog_we = 1'b0; bus.clr_bp = 1'b0;
  endtask

  task automatic prog_rd(input string tag, input int ch, input logic sel, input logic [7:0] e);
    logic [15:0] exp_v;
    exp_q.push_back({8'h00, e});
    bus.prog_re = 1'b1; bus.prog_sel = sel; bus.prog_ch = 2'(ch);
    @(negedge clk);
    bus.prog_re = 1'b0;
    exp_v = exp_q.pop_front();
    check_val(tag, {24'h0, bus.prog_rdata}, {16'h0, exp_v});
  endtask

  task automatic pulse_clr_bp();
    bus.clr_bp = 1'b1;
    @(negedge clk);
    bus.clr_bp = 1'b0;
  endtask

  task automatic pulse_status_rd();
    status_rd = 1'b1;
    @(negedge clk);
    status_rd = 1'b0;
  endtask

  // One svc_req/xfer_ack pair with all observable timing checked.
  task automatic do_xfer(input string tag, input int ch, input logic [15:0] ea,
                         input logic estb, input logic [3:0] etc,
                         input logic rd_at_ack, input logic [3:0] est);
    logic [15:0] exp_a;
    addr_q.push_back(ea);
    bus.svc_req = 1'b1; bus.svc_ch = 2'(ch);
    @(negedge clk);
    bus.svc_req = 1'b0;
    check_val({tag, "_aen"}, {31'h0, bus.aen}, 32'h1);
    check_val({tag, "_adstb"}, {31'h0, bus.adstb}, {31'h0, estb});
    if (estb) begin
      @(negedge clk);
      check_val({tag, "_adstb_1cyc"}, {31'h0, bus.adstb}, 32'h0);
    end
    exp_a = addr_q.pop_front();
    check_val({tag, "_addr"}, {16'h0, bus.addr_out}, {16'h0, exp_a});
    bus.xfer_ack = 1'b1; status_rd = rd_at_ack;
    @(negedge clk);
    bus.xfer_ack = 1'b0; status_rd = 1'b0;
    check_val({tag, "_tc_pulse"}, {28'h0, tc_pulse}, {28'h0, etc});
    check_val({tag, "_busy"}, {31'h0, busy}, 32'h0);
    check_val({tag, "_tc_status"}, {28'h0, tc_status}, {28'h0, est});
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] exp_a;
    bus.prog_we = 0; bus.prog_re = 0; bus.prog_sel = 0; bus.prog_ch = 0;
    bus.prog_wdata = 0; bus.clr_bp = 0; bus.svc_req = 0; bus.svc_ch = 0;
    bus.xfer_ack = 0; cfg_dec = 0; cfg_autoinit = 0; status_rd = 0;

    repeat (3) @(negedge clk);
    check_val("rst_busy",      {31'h0, busy},          32'h0);
    check_val("rst_aen",       {31'h0, bus.aen},       32'h0);
    check_val("rst_adstb",     {31'h0, bus.adstb},     32'h0);
    check_val("rst_addr",      {16'h0, bus.addr_out},  32'h0);
    check_val("rst_tc_status", {28'h0, tc_status},     32'h0);
    check_val("rst_tc_pulse",  {28'h0, tc_pulse},      32'h0);
    check_val("rst_rdata",     {24'h0, bus.prog_rdata}, 32'h0);
    check_val("rst_state",     {30'h0, state_dbg},     32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // ch1: program and read back
    prog_wr(1, SEL_ADDR, 8'h34, 1'b0);
    prog_wr(1, SEL_ADDR, 8'h12, 1'b0);
    prog_wr(1, SEL_CNT,  8'h02, 1'b0);
    prog_wr(1, SEL_CNT,  8'h00, 1'b0);
    prog_rd("ch1_addr_lo", 1, SEL_ADDR, 8'h34);
    prog_rd("ch1_addr_hi", 1, SEL_ADDR, 8'h12);
    prog_rd("ch1_cnt_lo",  1, SEL_CNT,  8'h02);
    prog_rd("ch1_cnt_hi",  1, SEL_CNT,  8'h00);

    // ch1 incrementing: 3 transfers, ADSTB on the first, TC on the third
    do_xfer("ch1_x0", 1, 16'h1234, 1'b1, 4'b0000, 1'b0, 4'b0000);
    do_xfer("ch1_x1", 1, 16'h1235, 1'b0, 4'b0000, 1'b0, 4'b0000);
    do_xfer("ch1_x2", 1, 16'h1236, 1'b0, 4'b0010, 1'b0, 4'b0010);
    repeat (2) @(negedge clk);
    check_val("ch1_tc_sticky", {28'h0, tc_status}, 32'h2);
    pulse_status_rd();
    check_val("ch1_tc_clear", {28'h0, tc_status}, 32'h0);
    prog_rd("ch1_post_addr_lo", 1, SEL_ADDR, 8'h37);
    prog_rd("ch1_post_addr_hi", 1, SEL_ADDR, 8'h12);
    prog_rd("ch1_post_cnt_lo",  1, SEL_CNT,  8'hFF);
    prog_rd("ch1_post_cnt_hi",  1, SEL_CNT,  8'hFF);

    // ch0 decrementing across an upper-byte boundary
    cfg_dec = 4'b0001;
    prog_wr(0, SEL_ADDR, 8'h00, 1'b0);
    prog_wr(0, SEL_ADDR, 8'h01, 1'b0);
    prog_wr(0, SEL_CNT,  8'h01, 1'b0);
    prog_wr(0, SEL_CNT,  8'h00, 1'b0);
    do_xfer("ch0_x0", 0, 16'h0100, 1'b1, 4'b0000, 1'b0, 4'b0000);
    do_xfer("ch0_x1", 0, 16'h00FF, 1'b1, 4'b0001, 1'b0, 4'b0001);

    // ch2 autoinit at the address ceiling with count 0
    cfg_autoinit = 4'b0100;
    prog_wr(2, SEL_ADDR, 8'hFF, 1'b0);
    prog_wr(2, SEL_ADDR, 8'hFF, 1'b0);
    prog_wr(2, SEL_CNT,  8'h00, 1'b0);
    prog_wr(2, SEL_CNT,  8'h00, 1'b0);
    do_xfer("ch2_x0", 2, 16'hFFFF, 1'b1, 4'b0100, 1'b0, 4'b0101);
`ifdef DMA_AUTOINIT_EN
    prog_rd("ch2_addr_lo", 2, SEL_ADDR, 8'hFF);
    prog_rd("ch2_addr_hi", 2, SEL_ADDR, 8'hFF);
    prog_rd("ch2_cnt_lo",  2, SEL_CNT,  8'h00);
    prog_rd("ch2_cnt_hi",  2, SEL_CNT,  8'h00);
    // reload cleared upper_valid; TC again, and the set beats status_rd
    do_xfer("ch2_x1", 2, 16'hFFFF, 1'b1, 4'b0100, 1'b1, 4'b0100);
`else
    prog_rd("ch2_addr_lo", 2, SEL_ADDR, 8'h00);
    prog_rd("ch2_addr_hi", 2, SEL_ADDR, 8'h00);
    prog_rd("ch2_cnt_lo",  2, SEL_CNT,  8'hFF);
    prog_rd("ch2_cnt_hi",  2, SEL_CNT,  8'hFF);
    do_xfer("ch2_x1", 2, 16'h0000, 1'b1, 4'b0000, 1'b1, 4'b0000);
`endif

    // ch3: prog_we during S_ADDR is ignored and bp does not move
    prog_wr(3, SEL_ADDR, 8'h00, 1'b0);
    prog_wr(3, SEL_ADDR, 8'h50, 1'b0);
    prog_wr(3, SEL_CNT,  8'h05, 1'b0);
    prog_wr(3, SEL_CNT,  8'h00, 1'b0);
    addr_q.push_back(16'h5000);
    bus.svc_req = 1'b1; bus.svc_ch = 2'd3;
    @(negedge clk);
    bus.svc_req = 1'b0;
    check_val("ch3_adstb", {31'h0, bus.adstb}, 32'h1);
    @(negedge clk);
    prog_wr(3, SEL_ADDR, 8'hAA, 1'b0);
    check_val("ch3_busy_saddr", {31'h0, busy}, 32'h1);
    exp_a = addr_q.pop_front();
    check_val("ch3_addr", {16'h0, bus.addr_out}, {16'h0, exp_a});
    bus.xfer_ack = 1'b1;
    @(negedge clk);
    bus.xfer_ack = 1'b0;
    check_val("ch3_tc_pulse", {28'h0, tc_pulse}, 32'h0);
    prog_rd("ch3_blk_lo", 3, SEL_ADDR, 8'h01);
    prog_rd("ch3_blk_hi", 3, SEL_ADDR, 8'h50);

    // clr_bp together with prog_we leaves bp at 0
    prog_wr(3, SEL_ADDR, 8'h11, 1'b0);
    prog_wr(3, SEL_ADDR, 8'h50, 1'b0);
    prog_wr(3, SEL_ADDR, 8'h11, 1'b1);
    prog_wr(3, SEL_ADDR, 8'h22, 1'b0);
    pulse_clr_bp();
    prog_rd("clr_bp_lo", 3, SEL_ADDR, 8'h22);
    prog_rd("clr_bp_hi", 3, SEL_ADDR, 8'h50);

    // xfer_ack while idle is ignored
    bus.xfer_ack = 1'b1;
    @(negedge clk);
    bus.xfer_ack = 1'b0;
    check_val("idle_ack_tc", {28'h0, tc_pulse}, 32'h0);
    check_val("idle_ack_busy", {31'h0, busy}, 32'h0);
`ifdef DMA_AUTOINIT_EN
    do_xfer("ch3_x1", 3, 16'h5022, 1'b1, 4'b0000, 1'b0, 4'b0100);
`else
    do_xfer("ch3_x1", 3, 16'h5022, 1'b1, 4'b0000, 1'b0, 4'b0000);
`endif

    // reset asserted in S_UPPER
    bus.svc_req = 1'b1; bus.svc_ch = 2'd0;
    @(negedge clk);
    bus.svc_req = 1'b0;
    check_val("rst_mid_adstb_pre", {31'h0, bus.adstb}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check_val("rst_mid_aen",   {31'h0, bus.aen},   32'h0);
    check_val("rst_mid_adstb", {31'h0, bus.adstb}, 32'h0);
    check_val("rst_mid_busy",  {31'h0, busy},      32'h0);
    check_val("rst_mid_tcst",  {28'h0, tc_status}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    prog_rd("rst_ch0_addr_lo", 0, SEL_ADDR, 8'h00);
    prog_rd("rst_ch0_addr_hi", 0, SEL_ADDR, 8'h00);
    prog_rd("rst_ch3_cnt_lo",  3, SEL_CNT,  8'h00);
    prog_rd("rst_ch3_cnt_hi",  3, SEL_CNT,  8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
